// File: rtl/md_scheduler_if.sv
// HI/LO unit handshake bundle between EX/ID
// and the multiply/divide scheduler.
interface md_scheduler_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_in_ID;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Stall_MD;

  modport master (
    output start, op, A, B, md_in_ID,
    input  busy, HI, LO, Stall_MD
  );

  modport slave (
    input  start, op, A, B, md_in_ID,
    output busy, HI, LO, Stall_MD
  );
endinterface

// File: rtl/md_scheduler.sv
// Multiply/divide scheduler: fixed-latency
// occupancy, HI/LO ownership, ID stall request.
module md_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  md_scheduler_if.slave md
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CWR = $clog2(MAXC + 1);
  localparam int CW  = (CWR < 4) ? 4 : CWR;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   phi_q, phi_d;
  logic [31:0]   plo_q, plo_d;
  logic          pwr_q, pwr_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic is_md, is_div, is_mthi, is_mtlo;
  assign is_md   = (md.op[2] == 1'b0);
  assign is_div  = is_md && md.op[1];
  assign is_mthi = (md.op == 3'd4);
  assign is_mtlo = (md.op == 3'd5);

  // One 64-bit multiplier: signed product is
  // the low 64 bits of the sign-extended one.
  logic [31:0] a_ext, b_ext;
  logic [63:0] prod;
  assign a_ext = md.op[0] ? 32'd0 : {32{md.A[31]}};
  assign b_ext = md.op[0] ? 32'd0 : {32{md.B[31]}};
  assign prod  = {a_ext, md.A} * {b_ext, md.B};

  // Divide on magnitudes, then restore signs;
  // 0x80000000/-1 falls out as 0x80000000 rem 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] quo, rem, quo_s, rem_s;
  assign a_neg  = !md.op[0] && md.A[31];
  assign b_neg  = !md.op[0] && md.B[31];
  assign a_mag  = a_neg ? (32'd0 - md.A) : md.A;
  assign b_mag  = b_neg ? (32'd0 - md.B) : md.B;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign quo    = a_mag / b_safe;
  assign rem    = a_mag % b_safe;
  assign quo_s  = (a_neg ^ b_neg) ? (32'd0 - quo) : quo;
  assign rem_s  = a_neg ? (32'd0 - rem) : rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          unique case (1'b1)
            is_md: begin
              state_d = BUSY;
              if (is_div) begin
                cnt_d = CW'(DIV_CYCLES);
                phi_d = rem_s;
                plo_d = quo_s;
                pwr_d = (md.B != 32'd0);
              end else begin
                cnt_d = CW'(MULT_CYCLES);
                phi_d = prod[63:32];
                plo_d = prod[31:0];
                pwr_d = 1'b1;
              end
            end
            is_mthi: hi_d = md.A;
            is_mtlo: lo_d = md.A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign md.busy     = (state_q == BUSY);
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.Stall_MD = md.md_in_ID &&
    (md.busy || (md.start && is_md));

endmodule
